clock_ctrl: RTL and testbench
=============================

CLOCK_CTRL -- requirements
Module: clock_ctrl

Interface
REQ-001 Parameter TICK_DIV, default 50000000, clk cycles per 1 s tick (legal range 4..2^26).
REQ-002 Parameter KEY_SYNC, default 2, synchroniser flop stages on each key input (legal 2..3).
REQ-003 clk  input  1  single system clock; all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 key_mode  input  1  asynchronous mode push-button, active-high, pre-debounced.
REQ-006 key_inc  input  1  asynchronous increment push-button, active-high, pre-debounced.
REQ-007 key_clr  input  1  asynchronous clear push-button, active-high, pre-debounced.
REQ-008 sec_max  input  1  seconds slice at 59 (combinational flag from slice).
REQ-009 min_max  input  1  minutes slice at 59.
REQ-010 sec_inc / min_inc / hour_inc  output  1 each  one-cycle increment pulses to the counter slices.
REQ-011 clr_all  output  1  one-cycle synchronous clear pulse to all slices.
REQ-012 mode  output  2  current state encoding (see REQ-015).
REQ-013 blank  output  1  display blank for the field being set; toggles at 2 Hz in SET states, 0 in RUN.

Function
REQ-014 Prescaler SHALL count 0..TICK_DIV-1 and wrap, asserting internal tick for one cycle at TICK_DIV-1, plus half_tick at TICK_DIV/2-1 and TICK_DIV-1.
REQ-015 FSM states SHALL be RUN=0, SET_HOUR=1, SET_MIN=2, SET_SEC=3.
REQ-016 Each key SHALL pass through KEY_SYNC flops, then rising-edge detect giving one-cycle press pulse; held key produces exactly one pulse.
REQ-017 mode_press SHALL advance RUN->SET_HOUR->SET_MIN->SET_SEC->RUN, one step per press.
REQ-018 In RUN, tick SHALL pulse sec_inc same cycle; min_inc when tick & sec_max; hour_inc when tick & sec_max & min_max.
REQ-019 In SET_x, ticks SHALL NOT generate any increment; inc_press SHALL pulse only the selected field's inc, no cascade regardless of max flags.
REQ-020 Output pulses SHALL be registered: asserted the cycle after the causing tick/press, width exactly one cycle.
REQ-021 clr_press SHALL pulse clr_all in any state, reset prescaler to 0, leave mode unchanged; clr in same cycle as inc/tick SHALL suppress that cycle's increments.
REQ-022 mode_press and inc_press in same cycle: mode advance wins, increment dropped.
REQ-023 Entering any SET state SHALL reset prescaler to 0 and blank to 0; leaving SET_SEC to RUN SHALL reset prescaler so the first RUN tick is a full TICK_DIV cycles later.
REQ-024 blank SHALL toggle on half_tick while in SET states and be forced 0 in RUN.
REQ-025 inc_press SHALL force blank to 0 and restart blink phase (prescaler to 0) so the edited field is visible.

Reset
REQ-026 rst_n low SHALL asynchronously set: mode=RUN, prescaler=0, all sync/edge flops=0, sec_inc=min_inc=hour_inc=clr_all=0, blank=0.
REQ-027 Release of rst_n SHALL NOT create key press pulses, even if a key is held during release.
REQ-028 Reset mid-pulse SHALL clear the pulse immediately; no pulse issued on release.

Structure
REQ-029 Shared package clock_pkg SHALL hold the mode state encoding constants and the default TICK_DIV.
REQ-030 Sub-module key_edge (synchroniser + rising-edge detect, parameter KEY_SYNC) SHALL be instantiated three times; prescaler and FSM inline.

Verification
REQ-031 TICK_DIV=10, RUN, flags 0: after reset, sec_inc pulses every 10 cycles, min_inc/hour_inc stay 0.
REQ-032 RUN, sec_max=1, min_max=1 at tick: sec_inc, min_inc, hour_inc all pulse in the same cycle.
REQ-033 Press key_mode once, key_inc 3x (held 5 cycles each): mode=1, exactly 3 hour_inc pulses, no sec_inc across 50 cycles.
REQ-034 Four key_mode presses: mode sequence 1,2,3,0; blank toggles every 5 cycles only while mode!=0.
REQ-035 key_clr pressed during RUN with tick coincident: clr_all one pulse, no sec_inc that cycle, next sec_inc 10 cycles later.
REQ-036 Hold key_inc high, assert/release rst_n: no pulses after release; mode=0, all outputs 0 during reset.

Source files
------------

// File: rtl/clock_pkg.sv
// Shared definitions for the clock controller: mode state encoding and
// the default prescaler divide ratio.
package clock_pkg;

    localparam int unsigned TICK_DIV_DEFAULT = 50_000_000;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        SET_HOUR = 2'd1,
        SET_MIN  = 2'd2,
        SET_SEC  = 2'd3
    } mode_e;

    function automatic mode_e next_mode(input mode_e m);
        mode_e n;
        case (m)
            RUN:      n = SET_HOUR;
            SET_HOUR: n = SET_MIN;
            SET_MIN:  n = SET_SEC;
            default:  n = RUN;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/key_edge.sv
// Push-button synchroniser plus rising-edge detector; emits a one-cycle
// press pulse per key press and ignores keys already held at reset release.
module key_edge #(
    parameter int unsigned KEY_SYNC = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key,
    output logic press
);

    logic [KEY_SYNC-1:0] sync_q, sync_d;
    logic [KEY_SYNC:0]   arm_q, arm_d;
    logic                prev_q, prev_d;

    // The arm chain is one stage longer than the synchroniser, so prev_q has
    // already absorbed a key held through reset before detection is enabled.
    always_comb begin
        sync_d = {sync_q[KEY_SYNC-2:0], key};
        arm_d  = {arm_q[KEY_SYNC-1:0], 1'b1};
        prev_d = sync_q[KEY_SYNC-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            arm_q  <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            arm_q  <= arm_d;
            prev_q <= prev_d;
        end
    end

    assign press = arm_q[KEY_SYNC] & sync_q[KEY_SYNC-1] & ~prev_q;

endmodule

// File: rtl/clock_ctrl.sv
// Digital clock controller: 1 s prescaler, RUN/SET mode FSM driven by three
// push-buttons, registered increment/clear pulses and a 2 Hz set-mode blink.
module clock_ctrl
    import clock_pkg::*;
#(
    parameter int unsigned TICK_DIV = TICK_DIV_DEFAULT,
    parameter int unsigned KEY_SYNC = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_mode,
    input  logic       key_inc,
    input  logic       key_clr,
    input  logic       sec_max,
    input  logic       min_max,
    output logic       sec_inc,
    output logic       min_inc,
    output logic       hour_inc,
    output logic       clr_all,
    output logic [1:0] mode,
    output logic       blank
);

    localparam int unsigned   CW   = $clog2(TICK_DIV);
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);
    localparam logic [CW-1:0] HALF = CW'(TICK_DIV / 2 - 1);

    logic          mode_press, inc_press, clr_press;
    logic          tick, half_tick;
    logic [CW-1:0] cnt_q, cnt_d;
    mode_e         mode_q, mode_d;
    logic          blank_q, blank_d;
    logic          sec_inc_q, sec_inc_d;
    logic          min_inc_q, min_inc_d;
    logic          hour_inc_q, hour_inc_d;
    logic          clr_all_q, clr_all_d;

    key_edge #(.KEY_SYNC(KEY_SYNC)) u_key_mode (
        .clk   (clk),
        .rst_n (rst_n),
        .key   (key_mode),
        .press (mode_press)
    );

    key_edge #(.KEY_SYNC(KEY_SYNC)) u_key_inc (
        .clk   (clk),
        .rst_n (rst_n),
        .key   (key_inc),
        .press (inc_press)
    );

    key_edge #(.KEY_SYNC(KEY_SYNC)) u_key_clr (
        .clk   (clk),
        .rst_n (rst_n),
        .key   (key_clr),
        .press (clr_press)
    );

    assign tick      = (cnt_q == LAST);
    assign half_tick = (cnt_q == HALF) || tick;

    // Priority: clear, then mode advance, then per-mode tick/increment work.
    always_comb begin
        cnt_d      = tick ? '0 : cnt_q + CW'(1);
        mode_d     = mode_q;
        blank_d    = blank_q;
        sec_inc_d  = 1'b0;
        min_inc_d  = 1'b0;
        hour_inc_d = 1'b0;
        clr_all_d  = 1'b0;

        if (clr_press) begin
            clr_all_d = 1'b1;
            cnt_d     = '0;
        end else if (mode_press) begin
            mode_d  = next_mode(mode_q);
            cnt_d   = '0;
            blank_d = 1'b0;
        end else if (mode_q == RUN) begin
            blank_d    = 1'b0;
            sec_inc_d  = tick;
            min_inc_d  = tick & sec_max;
            hour_inc_d = tick & sec_max & min_max;
        end else if (inc_press) begin
            cnt_d   = '0;
            blank_d = 1'b0;
            case (mode_q)
                SET_HOUR: hour_inc_d = 1'b1;
                SET_MIN:  min_inc_d  = 1'b1;
                SET_SEC:  sec_inc_d  = 1'b1;
                default:  ;
            endcase
        end else if (half_tick) begin
            blank_d = ~blank_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            mode_q     <= RUN;
            blank_q    <= 1'b0;
            sec_inc_q  <= 1'b0;
            min_inc_q  <= 1'b0;
            hour_inc_q <= 1'b0;
            clr_all_q  <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            mode_q     <= mode_d;
            blank_q    <= blank_d;
            sec_inc_q  <= sec_inc_d;
            min_inc_q  <= min_inc_d;
            hour_inc_q <= hour_inc_d;
            clr_all_q  <= clr_all_d;
        end
    end

    assign sec_inc  = sec_inc_q;
    assign min_inc  = min_inc_q;
    assign hour_inc = hour_inc_q;
    assign clr_all  = clr_all_q;
    assign mode     = mode_q;
    assign blank    = blank_q;

endmodule

// File: tb/tb_clock_ctrl.sv
// Directed bench for clock_ctrl (TICK_DIV=10): output pulses are matched
// against a scoreboard of expected {cycle, pulse vector} entries.
module tb_clock_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       key_mode, key_inc, key_clr;
    logic       sec_max, min_max;
    logic       sec_inc, min_inc, hour_inc, clr_all;
    logic [1:0] mode;
    logic       blank;

    int checks = 0;
    int passed = 0;
    int cyc    = 0;
    int r0, r2, s;

    typedef struct {
        int         cyc;
        logic [3:0] vec;   // {sec_inc, min_inc, hour_inc, clr_all}
    } exp_t;

    exp_t exp_q[$];

    clock_ctrl #(.TICK_DIV(10), .KEY_SYNC(2)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .key_mode (key_mode),
        .key_inc  (key_inc),
        .key_clr  (key_clr),
        .sec_max  (sec_max),
        .min_max  (min_max),
        .sec_inc  (sec_inc),
        .min_inc  (min_inc),
        .hour_inc (hour_inc),
        .clr_all  (clr_all),
        .mode     (mode),
        .blank    (blank)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    endtask

    task automatic expect_pulse(input int c, input logic [3:0] v);
        exp_t e;
        e.cyc = c;
        e.vec = v;
        exp_q.push_back(e);
    endtask

    // One negedge: flag overdue expectations, then match any visible pulse.
    task automatic step();
        logic [3:0] obs;
        exp_t       e;
        @(negedge clk);
        while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            e = exp_q.pop_front();
            check("missed_pulse_cycle", 32'(cyc), 32'(e.cyc));
        end
        obs = {sec_inc, min_inc, hour_inc, clr_all};
        if (obs != 4'b0000) begin
            if (exp_q.size() == 0) begin
                check("spurious_pulse", 32'(obs), 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("pulse_cycle", 32'(cyc), 32'(e.cyc));
                check("pulse_vec", 32'(obs), 32'(e.vec));
            end
        end
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) step();
    endtask

    initial begin
        rst_n    = 1'b0;
        key_mode = 1'b0;
        key_inc  = 1'b0;
        key_clr  = 1'b0;
        sec_max  = 1'b0;
        min_max  = 1'b0;

        repeat (3) step();
        check("reset_outputs", 32'({sec_inc, min_inc, hour_inc, clr_all, blank}), 32'd0);
        check("reset_mode", 32'(mode), 32'd0);
        rst_n = 1'b1;
        r0 = cyc;

        // RUN with flags low: plain seconds ticks every 10 cycles
        expect_pulse(r0 + 10, 4'b1000);
        expect_pulse(r0 + 20, 4'b1000);
        expect_pulse(r0 + 30, 4'b1000);
        wait_until(r0 + 35);
        check("run_sb_empty", 32'(exp_q.size()), 32'd0);

        // Cascade at a tick
        sec_max = 1'b1;
        min_max = 1'b1;
        expect_pulse(r0 + 40, 4'b1110);
        wait_until(r0 + 41);
        min_max = 1'b0;
        expect_pulse(r0 + 50, 4'b1100);
        wait_until(r0 + 51);
        sec_max = 1'b0;

        // Enter SET_HOUR, blink and three hour increments
        key_mode = 1'b1;
        s = r0 + 54;
        wait_until(s);
        check("mode_set_hour", 32'(mode), 32'd1);
        check("blank_enter", 32'(blank), 32'd0);
        wait_until(s + 2);
        key_mode = 1'b0;
        wait_until(s + 5);
        check("blank_toggle1", 32'(blank), 32'd1);
        wait_until(s + 10);
        check("blank_toggle2", 32'(blank), 32'd0);
        for (int i = 0; i < 3; i++) begin
            wait_until(s + 12 + 10 * i);
            key_inc = 1'b1;
            expect_pulse(s + 15 + 10 * i, 4'b0010);
            wait_until(s + 15 + 10 * i);
            check("blank_after_inc", 32'(blank), 32'd0);
            wait_until(s + 17 + 10 * i);
            key_inc = 1'b0;
            if (i == 0) begin
                wait_until(s + 20);
                check("blink_restart", 32'(blank), 32'd1);
            end
        end
        wait_until(s + 50);
        check("hour_sb_empty", 32'(exp_q.size()), 32'd0);
        check("mode_still_hour", 32'(mode), 32'd1);

        // SET_MIN / SET_SEC increments without cascade, then mode+inc together
        sec_max  = 1'b1;
        min_max  = 1'b1;
        key_mode = 1'b1;
        wait_until(s + 53);
        check("mode_set_min", 32'(mode), 32'd2);
        check("blank_mode_change", 32'(blank), 32'd0);
        wait_until(s + 55);
        key_mode = 1'b0;
        key_inc  = 1'b1;
        expect_pulse(s + 58, 4'b0100);
        wait_until(s + 57);
        key_inc = 1'b0;
        wait_until(s + 60);
        key_mode = 1'b1;
        wait_until(s + 62);
        key_mode = 1'b0;
        wait_until(s + 63);
        check("mode_set_sec", 32'(mode), 32'd3);
        wait_until(s + 65);
        key_inc = 1'b1;
        expect_pulse(s + 68, 4'b1000);
        wait_until(s + 67);
        key_inc = 1'b0;
        wait_until(s + 70);
        key_mode = 1'b1;
        key_inc  = 1'b1;
        wait_until(s + 72);
        key_mode = 1'b0;
        key_inc  = 1'b0;
        sec_max  = 1'b0;
        min_max  = 1'b0;
        wait_until(s + 73);
        check("mode_run_again", 32'(mode), 32'd0);
        check("blank_run", 32'(blank), 32'd0);
        expect_pulse(s + 83, 4'b1000);
        wait_until(s + 78);
        check("blank_run_hold", 32'(blank), 32'd0);

        // Clear coincident with a tick restarts the prescaler
        wait_until(s + 90);
        key_clr = 1'b1;
        expect_pulse(s + 93, 4'b0001);
        expect_pulse(s + 103, 4'b1000);
        wait_until(s + 95);
        key_clr = 1'b0;
        check("mode_after_clr", 32'(mode), 32'd0);
        wait_until(s + 104);
        check("clr_sb_empty", 32'(exp_q.size()), 32'd0);

        // Reset mid-pulse with keys held through release
        key_inc = 1'b1;
        expect_pulse(s + 113, 4'b1000);
        wait_until(s + 113);
        #2;
        rst_n    = 1'b0;
        key_mode = 1'b1;
        key_clr  = 1'b1;
        #1;
        check("reset_kills_pulse", 32'(sec_inc), 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("in_reset_outputs", 32'({sec_inc, min_inc, hour_inc, clr_all, blank}), 32'd0);
            check("in_reset_mode", 32'(mode), 32'd0);
        end
        rst_n = 1'b1;
        r2 = cyc;
        expect_pulse(r2 + 10, 4'b1000);
        expect_pulse(r2 + 20, 4'b1000);
        wait_until(r2 + 15);
        check("held_mode_no_press", 32'(mode), 32'd0);
        wait_until(r2 + 25);
        check("held_mode_still_run", 32'(mode), 32'd0);
        check("held_sb_empty", 32'(exp_q.size()), 32'd0);
        key_mode = 1'b0;
        key_inc  = 1'b0;
        key_clr  = 1'b0;
        wait_until(r2 + 29);
        check("final_sb_empty", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
